// File: rtl/bus_xfer_ctrl_if.sv
// Request/response and tri-state bus-interface signals of the transfer controller.
// slave is the controller's view; master is the requester/bus-side view.
interface bus_xfer_ctrl_if;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       wr_ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       send;
    logic [7:0] data_to_bus;
    logic       rcv;
    logic [7:0] data_from_bus;

    modport slave (
        input  wr_req,
        input  wr_data,
        input  rd_req,
        input  data_from_bus,
        output wr_ack,
        output rd_data,
        output rd_valid,
        output busy,
        output send,
        output data_to_bus,
        output rcv
    );

    modport master (
        output wr_req,
        output wr_data,
        output rd_req,
        output data_from_bus,
        input  wr_ack,
        input  rd_data,
        input  rd_valid,
        input  busy,
        input  send,
        input  data_to_bus,
        input  rcv
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Half-duplex single-byte transfer sequencer for an 8-bit tri-state bus interface.
// One DRIVE or SAMPLE cycle per transfer, then TURN_CYC idle turnaround cycles.
module bus_xfer_ctrl #(
    parameter int unsigned TURN_CYC = 1
) (
    input logic             clk,
    input logic             reset,
    bus_xfer_ctrl_if.slave  xfer
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StTurn} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_wr_q, last_wr_d;
    logic       grant_wr, grant_rd;

    logic       send_q;
    logic       rcv_q;
    logic       wr_ack_q;
    logic       rd_valid_q;
    logic       busy_q;
    logic [7:0] data_to_bus_q;
    logic [7:0] rd_data_q;

    localparam logic [3:0] TurnLoad = 4'(TURN_CYC - 1);

    // On a tie, grant whichever type was not served last.
    always_comb begin
        grant_wr = xfer.wr_req && !(xfer.rd_req && last_wr_q);
        grant_rd = xfer.rd_req && !grant_wr;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d = StDrive;
                end else if (grant_rd) begin
                    state_d = StSample;
                end
            end
            StDrive: begin
                state_d   = StTurn;
                cnt_d     = TurnLoad;
                last_wr_d = 1'b1;
            end
            StSample: begin
                state_d   = StTurn;
                cnt_d     = TurnLoad;
                last_wr_d = 1'b0;
            end
            StTurn: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered decodes of the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            last_wr_q     <= 1'b0;
            send_q        <= 1'b0;
            rcv_q         <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            data_to_bus_q <= 8'h00;
            rd_data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_wr_q  <= last_wr_d;
            send_q     <= (state_d == StDrive);
            wr_ack_q   <= (state_d == StDrive);
            rcv_q      <= (state_d == StSample);
            busy_q     <= (state_d != StIdle);
            rd_valid_q <= (state_q == StSample);
            if (state_q == StSample) begin
                rd_data_q <= xfer.data_from_bus;
            end
            if ((state_q == StIdle) && (state_d == StDrive)) begin
                data_to_bus_q <= xfer.wr_data;
            end
        end
    end

    assign xfer.send        = send_q;
    assign xfer.rcv         = rcv_q;
    assign xfer.wr_ack      = wr_ack_q;
    assign xfer.rd_valid    = rd_valid_q;
    assign xfer.busy        = busy_q;
    assign xfer.data_to_bus = data_to_bus_q;
    assign xfer.rd_data     = rd_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: transaction-level timing model plus a TURN_CYC=15 check.
module tb_bus_xfer_ctrl;

    localparam int T = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bus_xfer_ctrl_if b ();
    bus_xfer_ctrl_if b15 ();

    bus_xfer_ctrl #(.TURN_CYC(T)) dut (
        .clk   (clk),
        .reset (reset),
        .xfer  (b.slave)
    );

    bus_xfer_ctrl #(.TURN_CYC(15)) dut15 (
        .clk   (clk),
        .reset (reset),
        .xfer  (b15.slave)
    );

    typedef struct {
        logic       is_wr;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       q[$];
    logic [7:0] dfb_hist[int];
    int         cyc = 0;
    int         g = -1000;
    logic       g_wr = 1'b0;
    logic       last_wr = 1'b0;
    logic [7:0] exp_dtb = 8'h00;
    logic [7:0] exp_rd = 8'h00;
    logic       mon_en = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; the model grants per the arbitration and timing rules.
    task automatic step(input logic w, input logic r, input logic [7:0] wd,
                        input logic [7:0] dfb, input logic rst_n);
        logic gw;
        @(negedge clk);
        #1;
        reset           = rst_n;
        b.wr_req        = w;
        b.rd_req        = r;
        b.wr_data       = wd;
        b.data_from_bus = dfb;
        dfb_hist[cyc]   = dfb;
        if (!rst_n) begin
            q.delete();
            g       = -1000;
            g_wr    = 1'b0;
            last_wr = 1'b0;
            exp_dtb = 8'h00;
            exp_rd  = 8'h00;
        end else if ((cyc >= g + 2 + T) && (w || r)) begin
            gw      = w && !(r && last_wr);
            g       = cyc;
            g_wr    = gw;
            last_wr = gw;
            q.push_back('{is_wr: gw, data: wd, due: cyc + (gw ? 1 : 2)});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (b.wr_ack || b.rd_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_response", {30'd0, b.wr_ack, b.rd_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_kind", {31'd0, b.wr_ack}, {31'd0, e.is_wr});
                    chk("resp_cycle", cyc, e.due);
                    if (e.is_wr) begin
                        exp_dtb = e.data;
                    end else begin
                        exp_rd = dfb_hist[e.due - 1];
                    end
                end
            end else if (q.size() > 0 && q[0].due < cyc) begin
                chk("missing_response_due", cyc, q[0].due);
                void'(q.pop_front());
            end
            chk("send", {31'd0, b.send}, {31'd0, (cyc == g + 1) && g_wr});
            chk("rcv", {31'd0, b.rcv}, {31'd0, (cyc == g + 1) && !g_wr});
            chk("busy", {31'd0, b.busy}, {31'd0, (cyc > g) && (cyc < g + 2 + T)});
            chk("send_rcv_excl", {31'd0, b.send & b.rcv}, 32'd0);
            chk("data_to_bus", {24'd0, b.data_to_bus}, {24'd0, exp_dtb});
            chk("rd_data", {24'd0, b.rd_data}, {24'd0, exp_rd});
        end
    end

    initial begin
        int   n;
        logic busy15[1:20];
        logic ack15[1:20];
        logic rcv15[1:20];
        logic vld15[1:20];
        logic [7:0] dtb15;
        logic [7:0] rd15;
        int   nbusy;

        b.wr_req = 0; b.rd_req = 0; b.wr_data = 0; b.data_from_bus = 0;
        b15.wr_req = 0; b15.rd_req = 0; b15.wr_data = 0; b15.data_from_bus = 8'hC3;
        dtb15 = 0; rd15 = 0;

        // Reset held with both requests high.
        step(1, 1, 8'h11, 8'h22, 0);
        mon_en = 1'b1;
        step(1, 1, 8'h11, 8'h22, 0);
        step(1, 1, 8'h11, 8'h22, 0);

        // Ties held from reset alternate W,R,W,R.
        for (int i = 0; i < 13; i++) step(1, 1, 8'(8'h40 + i), 8'(8'h90 + i), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 1);

        // Single write, then data_to_bus must hold.
        step(1, 0, 8'hA5, 8'h00, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 8'h00, 1);

        // Single read; later bus changes must not touch rd_data.
        step(0, 1, 8'h00, 8'hFF, 1);
        step(0, 0, 8'h00, 8'h3C, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 8'hFF, 1);

        // Read pulse during a write's TURN is ignored; a held read is granted later.
        step(1, 0, 8'h5B, 8'h00, 1);
        step(0, 0, 8'h00, 8'h00, 1);
        step(0, 1, 8'h00, 8'h00, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 1);
        step(1, 0, 8'h6C, 8'h00, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 8'(8'h20 + i), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 1);

        // Reset sampled during SAMPLE drops the read.
        step(0, 1, 8'h00, 8'h00, 1);
        step(0, 0, 8'h00, 8'h77, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h77, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), 8'($urandom), ($urandom_range(0, 60) != 0));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 8'h00, 1);
        chk("queue_drained", q.size(), 32'd0);

        // TURN_CYC=15 instance: write then a held read.
        step(0, 0, 8'h00, 8'h00, 1);
        b15.wr_req  = 1'b1;
        b15.wr_data = 8'h5A;
        n = cyc;
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 8'h00, 8'h00, 1);
            if (k == 1) begin
                b15.wr_req = 1'b0;
                b15.rd_req = 1'b1;
                dtb15 = b15.data_to_bus;
            end
            if (k == 18) b15.rd_req = 1'b0;
            if (k == 19) rd15 = b15.rd_data;
            busy15[k] = b15.busy;
            ack15[k]  = b15.wr_ack;
            rcv15[k]  = b15.rcv;
            vld15[k]  = b15.rd_valid;
        end
        nbusy = 0;
        for (int k = 1; k <= 16; k++) nbusy += int'(busy15[k]);
        chk("t15_cycle_base", cyc, n + 20);
        chk("t15_wr_ack", {31'd0, ack15[1]}, 32'd1);
        chk("t15_data_to_bus", {24'd0, dtb15}, 32'h5A);
        chk("t15_busy_count", nbusy, 32'd16);
        chk("t15_idle_at_17", {31'd0, busy15[17]}, 32'd0);
        chk("t15_no_rcv_at_17", {31'd0, rcv15[17]}, 32'd0);
        chk("t15_rcv_at_18", {31'd0, rcv15[18]}, 32'd1);
        chk("t15_rd_valid_at_19", {31'd0, vld15[19]}, 32'd1);
        chk("t15_rd_data", {24'd0, rd15}, 32'hC3);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
